// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter granting two requesters one-at-a-time use of a shared combinational ALU.
module alu_share_arbiter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   input  logic         req1_valid,
   output logic         req0_ready,
   output logic         req1_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic [2:0]   req0_f,
   input  logic [2:0]   req1_f,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [2:0]   alu_f,
   input  logic [W-1:0] alu_y,
   input  logic         alu_zero,
   input  logic         alu_overflow,
   output logic         resp0_valid,
   output logic         resp1_valid,
   input  logic         resp0_ready,
   input  logic         resp1_ready,
   output logic [W-1:0] resp_y,
   output logic         resp_zero,
   output logic         resp_overflow
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state;
   logic   last;
   logic   owner;
   logic   acc0, acc1, resp_done;
   // last = requester served most recently; each ready sees only the other side's valid
   assign req0_ready = (state == IDLE) & (last | ~req1_valid);
   assign req1_ready = (state == IDLE) & (~last | ~req0_valid);
   assign acc0       = req0_valid & req0_ready;
   assign acc1       = req1_valid & req1_ready;
   assign resp_done  = owner ? resp1_ready : resp0_ready;
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         last          <= 1'b1;
         owner         <= 1'b0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_f         <= '0;
         resp0_valid   <= 1'b0;
         resp1_valid   <= 1'b0;
         resp_y        <= '0;
         resp_zero     <= 1'b0;
         resp_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: if (acc0 | acc1) begin
               alu_a <= acc1 ? req1_a : req0_a;
               alu_b <= acc1 ? req1_b : req0_b;
               alu_f <= acc1 ? req1_f : req0_f;
               owner <= acc1;
               state <= EXEC;
            end
            EXEC: begin
               resp_y        <= alu_y;
               resp_zero     <= alu_zero;
               resp_overflow <= alu_overflow;
               resp0_valid   <= ~owner;
               resp1_valid   <= owner;
               state         <= RESP;
            end
            RESP: if (resp_done) begin
               resp0_valid <= 1'b0;
               resp1_valid <= 1'b0;
               last        <= owner;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed scoreboard bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0]  req0_f = '0, req1_f = '0;
   logic [31:0] alu_a, alu_b, alu_y;
   logic [2:0]  alu_f;
   logic        alu_zero, alu_overflow;
   logic        resp0_valid, resp1_valid;
   logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
   logic [31:0] resp_y;
   logic        resp_zero, resp_overflow;

   typedef struct {
      logic        own;
      logic [31:0] y;
      logic        z;
      logic        v;
   } exp_t;
   exp_t q[$];
   int tests = 0, fails = 0, cyc = 0;

   alu_share_arbiter #(.W(32)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_f(req0_f), .req1_f(req1_f),
      .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
      .alu_y(alu_y), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
      .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
      .resp_y(resp_y), .resp_zero(resp_zero), .resp_overflow(resp_overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural stand-in for the team ALU: and/or/add/sub/slt, other codes give 0
   always_comb begin
      alu_y        = '0;
      alu_overflow = 1'b0;
      case (alu_f)
         3'b000: alu_y = alu_a & alu_b;
         3'b001: alu_y = alu_a | alu_b;
         3'b010: begin
            alu_y        = alu_a + alu_b;
            alu_overflow = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
         end
         3'b110: begin
            alu_y        = alu_a - alu_b;
            alu_overflow = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
         end
         3'b111: alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
         default: alu_y = '0;
      endcase
      alu_zero = (alu_y == 32'b0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare each delivered response (valid & ready) with the head of the scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (resp0_valid && resp1_valid) chk("both_resp_valid", 1, 0);
         if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
            if (q.size() == 0) chk("unexpected_resp", 1, 0);
            else begin
               exp_t e;
               e = q.pop_front();
               chk("resp_owner", resp1_valid, e.own);
               chk("resp_y", resp_y, e.y);
               chk("resp_zero", resp_zero, e.z);
               chk("resp_overflow", resp_overflow, e.v);
            end
         end
      end
   end

   task automatic issue(input bit n, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
      bit ok;
      @(posedge clk); #1;
      if (n) begin req1_valid = 1; req1_a = a; req1_b = b; req1_f = f; end
      else   begin req0_valid = 1; req0_a = a; req0_b = b; req0_f = f; end
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = n ? req1_ready : req0_ready;
      end
      chk("accept_seen", ok, 1);
      @(posedge clk); #1;
      req0_valid = 0;
      req1_valid = 0;
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(negedge clk);
         if (resp0_valid || resp1_valid) lat = i;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, n, prev;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rst_resp0_valid", resp0_valid, 0);
      chk("rst_resp1_valid", resp1_valid, 0);
      chk("rst_resp_y", resp_y, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_f", alu_f, 0);

      // 5 - 3 = 2, two-cycle latency
      resp0_ready = 1;
      q.push_back('{0, 32'd2, 0, 0});
      issue(0, 32'd5, 32'd3, 3'b110);
      chk("alu_a_latched", alu_a, 32'd5);
      wait_resp(lat);
      chk("latency_req0", lat, 2);
      chk("resp1_quiet", resp1_valid, 0);
      drain();

      // Signed overflow, response held while resp1_ready low; resp0_ready must be ignored
      resp0_ready = 1;
      resp1_ready = 0;
      q.push_back('{1, 32'h8000_0000, 0, 1});
      issue(1, 32'h7FFF_FFFF, 32'd1, 3'b010);
      wait_resp(lat);
      chk("latency_req1", lat, 2);
      for (int i = 0; i < 5; i++) begin
         chk("hold_resp1_valid", resp1_valid, 1);
         chk("hold_resp_y", resp_y, 32'h8000_0000);
         chk("hold_readies", {req0_ready, req1_ready}, 0);
         @(negedge clk);
      end
      @(posedge clk); #1 resp1_ready = 1;
      drain();

      // Zero result, and the 011 code is accepted like any other
      q.push_back('{0, 32'd0, 1, 0});
      issue(0, 32'd9, 32'd9, 3'b110);
      drain();
      q.push_back('{1, 32'd0, 1, 0});
      issue(1, 32'd4, 32'd5, 3'b011);
      chk("alu_f_forwarded", alu_f, 3'b011);
      drain();

      // Both requesters always valid after reset: grants 0,1,0,1 every 3 cycles
      @(posedge clk); #1 reset = 1;
      req0_valid = 1; req0_a = 32'd10; req0_b = 32'd1; req0_f = 3'b010;
      req1_valid = 1; req1_a = 32'd20; req1_b = 32'd3; req1_f = 3'b110;
      for (int i = 0; i < 2; i++) begin
         q.push_back('{0, 32'd11, 0, 0});
         q.push_back('{1, 32'd17, 0, 0});
      end
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("first_grant", {req0_ready, req1_ready}, 2'b10);
      n = 0;
      prev = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         if (i > 0) @(negedge clk);
         if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            if (n > 0) chk("accept_spacing", cyc - prev, 3);
            prev = cyc;
            n++;
            if (n == 4) begin
               @(posedge clk); #1;
               req0_valid = 0;
               req1_valid = 0;
            end
         end
      end
      chk("accepts_seen", n, 4);
      drain();

      // Reset during EXEC abandons the transaction
      @(posedge clk); #1;
      req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1; req0_f = 3'b010;
      @(negedge clk);
      chk("pre_exec_ready", req0_ready, 1);
      @(posedge clk); #1 reset = 1;
      @(negedge clk);
      chk("exec_alu_a", alu_a, 32'd1);
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("post_rst_ready0", req0_ready, 1);
      chk("post_rst_resp0", resp0_valid, 0);
      chk("post_rst_alu_a", alu_a, 0);
      req0_valid = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_resp_after_rst", {resp0_valid, resp1_valid}, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
